// File: rtl/timer_pkg.sv
// Shared definitions for the timer step sequencer.
//   - state_e   : sequencer FSM states
//   - MAX_SEC   : largest step duration accepted (writes clamp to it)
//   - ALARM_SEC : seconds the alarm holds before auto-advancing
//   - idx_w/cnt_w : width helpers for step index and alarm counter
package timer_pkg;

  localparam int STEPS_DEF = 4;
  localparam int VAL_W_DEF = 12;
  localparam int MAX_SEC   = 3600;
  localparam int ALARM_SEC = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    ALARM  = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Step index width; never below 1 so a single-step build still has a port.
  function automatic int idx_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  // Width of a down-counter that must hold the value n.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/step_store.sv
// STEPS x VAL_W register file holding the programmed step durations.
//   clk, reset      : clock, async active-high clear of every entry
//   we/waddr/wdata  : synchronous write, data clamped to MAX_SEC
//   raddr_a/rdata_a : combinational read port (current step)
//   raddr_b/rdata_b : combinational read port (look-ahead step)
module step_store
  import timer_pkg::*;
#(
  parameter int STEPS   = STEPS_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int MAX_VAL = MAX_SEC,
  parameter int IDX_W   = idx_w(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [VAL_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr_a,
  output logic [VAL_W-1:0] rdata_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [VAL_W-1:0] rdata_b
);

  localparam logic [VAL_W-1:0] CLAMP = VAL_W'(MAX_VAL);

  logic [VAL_W-1:0] mem_q [STEPS];
  logic [VAL_W-1:0] mem_d [STEPS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = (wdata > CLAMP) ? CLAMP : wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/timer_step_sequencer.sv
// Runs the countdown timer through a programmed list of step durations.
//   tick_1hz          : 1 Hz enable pulse (paces the alarm hold)
//   prog_we/addr/data : step store write (only accepted in IDLE/DONE)
//   num_steps, go     : number of steps to run, start pulse
//   pause_req, ack    : pause toggle, alarm silence / leave DONE
//   abort             : back to IDLE, beats every other input
//   tmr_zero          : timer has reached zero
//   tmr_load/value    : load pulse + duration for the timer
//   tmr_run           : timer count enable
//   step_idx, busy, alarm, done_all : status
// All outputs except tmr_value are registered from the next state, so
// they line up with the state register.
module timer_step_sequencer
  import timer_pkg::*;
#(
  parameter int STEPS     = STEPS_DEF,
  parameter int VAL_W     = VAL_W_DEF,
  parameter int MAX_SEC   = timer_pkg::MAX_SEC,
  parameter int ALARM_SEC = timer_pkg::ALARM_SEC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_1hz,
  input  logic                     prog_we,
  input  logic [$clog2(STEPS)-1:0] prog_addr,
  input  logic [VAL_W-1:0]         prog_data,
  input  logic [$clog2(STEPS):0]   num_steps,
  input  logic                     go,
  input  logic                     pause_req,
  input  logic                     ack,
  input  logic                     abort,
  input  logic                     tmr_zero,
  output logic                     tmr_load,
  output logic [VAL_W-1:0]         tmr_value,
  output logic                     tmr_run,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     busy,
  output logic                     alarm,
  output logic                     done_all
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int CNT_W = cnt_w(ALARM_SEC);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic             first_q, first_d;
  logic             tmr_load_q, tmr_load_d;
  logic             tmr_run_q, tmr_run_d;
  logic             busy_q, busy_d;
  logic             alarm_q, alarm_d;
  logic             done_q, done_d;

  logic [VAL_W-1:0] cur_val, next_val;
  logic             last_step, go_ok, store_we;
  logic [IDX_W:0]   go_count;

  // Port a feeds the timer; port b looks at the step the FSM is heading
  // into, so the registered tmr_load already knows whether to skip it.
  step_store #(
    .STEPS  (STEPS),
    .VAL_W  (VAL_W),
    .MAX_VAL(MAX_SEC),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .we     (store_we),
    .waddr  (prog_addr),
    .wdata  (prog_data),
    .raddr_a(step_idx_q),
    .rdata_a(cur_val),
    .raddr_b(step_idx_d),
    .rdata_b(next_val)
  );

  assign go_ok     = go && (num_steps != '0);
  assign go_count  = (num_steps > (IDX_W+1)'(STEPS)) ? (IDX_W+1)'(STEPS) : num_steps;
  assign last_step = ({1'b0, step_idx_q} == (count_q - (IDX_W+1)'(1)));

  always_comb begin
    state_d     = state_q;
    step_idx_d  = step_idx_q;
    count_d     = count_q;
    alarm_cnt_d = alarm_cnt_q;
    first_d     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (go_ok) begin
          state_d    = LOAD;
          step_idx_d = '0;
          count_d    = go_count;
        end else if (ack && state_q == DONE) begin
          state_d    = IDLE;
          step_idx_d = '0;
        end
      end
      LOAD: begin
        if (cur_val == '0) begin
          // Zero-length step: skip straight to the next one, no alarm.
          if (last_step) state_d = DONE;
          else           step_idx_d = step_idx_q + IDX_W'(1);
        end else begin
          state_d = RUN;
          first_d = 1'b1;
        end
      end
      RUN: begin
        // tmr_zero is stale in the first RUN cycle (timer loads one late).
        if (tmr_zero && !first_q) begin
          state_d     = ALARM;
          alarm_cnt_d = CNT_W'(ALARM_SEC);
        end else if (pause_req) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_req) state_d = RUN;
      end
      ALARM: begin
        if (ack || (tick_1hz && alarm_cnt_q == CNT_W'(1))) begin
          alarm_cnt_d = '0;
          if (last_step) begin
            state_d = DONE;
          end else begin
            state_d    = LOAD;
            step_idx_d = step_idx_q + IDX_W'(1);
          end
        end else if (tick_1hz) begin
          alarm_cnt_d = alarm_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      step_idx_d  = '0;
      alarm_cnt_d = '0;
      first_d     = 1'b0;
    end
  end

  // A write landing on the same edge as a start would race the look-ahead
  // load decision, so writes are only taken while the FSM stays put.
  assign store_we = prog_we && (state_q == IDLE || state_q == DONE) &&
                    (state_d == IDLE || state_d == DONE);

  always_comb begin
    tmr_load_d = (state_d == LOAD) && (next_val != '0);
    tmr_run_d  = (state_d == RUN);
    alarm_d    = (state_d == ALARM);
    done_d     = (state_d == DONE);
    busy_d     = (state_d == LOAD) || (state_d == RUN) ||
                 (state_d == PAUSED) || (state_d == ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_idx_q  <= '0;
      count_q     <= '0;
      alarm_cnt_q <= '0;
      first_q     <= 1'b0;
      tmr_load_q  <= 1'b0;
      tmr_run_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      count_q     <= count_d;
      alarm_cnt_q <= alarm_cnt_d;
      first_q     <= first_d;
      tmr_load_q  <= tmr_load_d;
      tmr_run_q   <= tmr_run_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign tmr_load  = tmr_load_q;
  assign tmr_value = cur_val;
  assign tmr_run   = tmr_run_q;
  assign step_idx  = step_idx_q;
  assign busy      = busy_q;
  assign alarm     = alarm_q;
  assign done_all  = done_q;

endmodule

// File: tb/tb_timer_step_sequencer.sv
// Directed bench for timer_step_sequencer; the timer itself is played by
// the bench driving tmr_zero by hand.
module tb_timer_step_sequencer;

  logic        clk, reset, tick_1hz, prog_we, go, pause_req, ack, abort, tmr_zero;
  logic [1:0]  prog_addr;
  logic [11:0] prog_data;
  logic [2:0]  num_steps;
  logic        tmr_load, tmr_run, busy, alarm, done_all;
  logic [11:0] tmr_value;
  logic [1:0]  step_idx;

  int vectors    = 0;
  int miscompares = 0;

  timer_step_sequencer dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .num_steps(num_steps), .go(go), .pause_req(pause_req), .ack(ack),
    .abort(abort), .tmr_zero(tmr_zero), .tmr_load(tmr_load),
    .tmr_value(tmr_value), .tmr_run(tmr_run), .step_idx(step_idx),
    .busy(busy), .alarm(alarm), .done_all(done_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [1:0] a, input logic [11:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic pulse_go(input logic [2:0] n);
    num_steps = n; go = 1'b1;
    cyc();
    go = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
  endtask

  task automatic zero();
    tmr_zero = 1'b1; cyc(); tmr_zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    num_steps = 0; go = 0; pause_req = 0; ack = 0; abort = 0; tmr_zero = 0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_run", 32'(tmr_run), 0);
    chk("rst_load", 32'(tmr_load), 0);
    chk("rst_done", 32'(done_all), 0);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_value", 32'(tmr_value), 0);
    #3 reset = 1'b0;
    cyc();

    // ---- two-step run {3,2} with auto-advance ----
    prog(0, 12'd3); prog(1, 12'd2);
    pulse_go(3'd2);
    chk("s0_load", 32'(tmr_load), 1);
    chk("s0_value", 32'(tmr_value), 3);
    chk("s0_busy", 32'(busy), 1);
    cyc();
    chk("s0_run", 32'(tmr_run), 1);
    chk("s0_load_gone", 32'(tmr_load), 0);
    zero();                                  // first RUN cycle: ignored
    chk("s0_first_zero_ignored", 32'(alarm), 0);
    chk("s0_still_run", 32'(tmr_run), 1);
    tick(); tick(); tick();
    zero();
    chk("s0_alarm", 32'(alarm), 1);
    chk("s0_alarm_run_off", 32'(tmr_run), 0);
    tick(); tick(); tick(); tick();
    chk("s0_alarm_hold4", 32'(alarm), 1);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    chk("s1_load", 32'(tmr_load), 1);
    chk("s1_value", 32'(tmr_value), 2);
    chk("s1_idx", 32'(step_idx), 1);
    chk("s1_alarm_off", 32'(alarm), 0);
    cyc(); cyc();
    zero();
    chk("s1_alarm", 32'(alarm), 1);
    tick(); tick(); tick(); tick();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    chk("seq_done", 32'(done_all), 1);
    chk("seq_done_busy", 32'(busy), 0);
    chk("seq_done_idx", 32'(step_idx), 1);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("ack_idle_done", 32'(done_all), 0);
    chk("ack_idle_idx", 32'(step_idx), 0);

    // ---- zero-length step skipped, then abort mid-RUN ----
    prog(0, 12'd0); prog(1, 12'd7);
    pulse_go(3'd2);
    chk("skip_no_load", 32'(tmr_load), 0);
    chk("skip_busy", 32'(busy), 1);
    cyc();
    chk("skip_next_load", 32'(tmr_load), 1);
    chk("skip_next_value", 32'(tmr_value), 7);
    chk("skip_next_idx", 32'(step_idx), 1);
    chk("skip_no_alarm", 32'(alarm), 0);
    cyc(); cyc();
    chk("abort_pre_run", 32'(tmr_run), 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_run_off", 32'(tmr_run), 0);
    chk("abort_run_busy", 32'(busy), 0);
    chk("abort_run_load", 32'(tmr_load), 0);

    // ---- pause, zero-beats-pause, ack/tick coincidence, ack after 2 ticks ----
    prog(0, 12'd3); prog(2, 12'd5);
    pulse_go(3'd3);
    cyc(); cyc();
    pause_req = 1'b1; cyc(); pause_req = 1'b0;
    chk("pause_run_off", 32'(tmr_run), 0);
    chk("pause_busy", 32'(busy), 1);
    pause_req = 1'b1; cyc(); pause_req = 1'b0;
    chk("resume_run", 32'(tmr_run), 1);
    pause_req = 1'b1; tmr_zero = 1'b1; cyc(); pause_req = 1'b0; tmr_zero = 1'b0;
    chk("zero_wins_alarm", 32'(alarm), 1);
    chk("zero_wins_run", 32'(tmr_run), 0);
    tick(); tick(); tick(); tick();
    tick_1hz = 1'b1; ack = 1'b1; cyc(); tick_1hz = 1'b0; ack = 1'b0;
    chk("acktick_load", 32'(tmr_load), 1);
    chk("acktick_idx", 32'(step_idx), 1);
    cyc();
    chk("acktick_single_idx", 32'(step_idx), 1);
    chk("acktick_run", 32'(tmr_run), 1);
    cyc();
    zero();
    tick(); tick();
    chk("ack2_alarm_on", 32'(alarm), 1);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("ack2_alarm_off", 32'(alarm), 0);
    chk("ack2_load", 32'(tmr_load), 1);
    chk("ack2_value", 32'(tmr_value), 5);
    chk("ack2_idx", 32'(step_idx), 2);
    cyc(); cyc();
    zero();
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("three_done", 32'(done_all), 1);

    // ---- clamp on write in DONE, write ignored in RUN ----
    prog(0, 12'd4000);
    pulse_go(3'd1);
    chk("clamp_value", 32'(tmr_value), 3600);
    cyc();
    prog(0, 12'd9);
    chk("run_write_ignored", 32'(tmr_value), 3600);
    abort = 1'b1; cyc(); abort = 1'b0;
    pulse_go(3'd1);
    chk("store_kept", 32'(tmr_value), 3600);
    abort = 1'b1; cyc(); abort = 1'b0;
    pulse_go(3'd0);
    chk("go0_idle_busy", 32'(busy), 0);
    chk("go0_no_load", 32'(tmr_load), 0);
    cyc();
    chk("go0_still_idle", 32'(busy), 0);

    // ---- abort mid-ALARM ----
    pulse_go(3'd1);
    cyc(); cyc();
    zero();
    chk("abort_alarm_pre", 32'(alarm), 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_alarm_off", 32'(alarm), 0);
    chk("abort_alarm_busy", 32'(busy), 0);

    // ---- async reset mid-PAUSED ----
    pulse_go(3'd1);
    cyc(); cyc();
    pause_req = 1'b1; cyc(); pause_req = 1'b0;
    chk("prereset_paused", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_run", 32'(tmr_run), 0);
    chk("areset_idx", 32'(step_idx), 0);
    chk("areset_store", 32'(tmr_value), 0);
    @(negedge clk) reset = 1'b0;
    cyc();
    chk("after_reset_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
